cpu_fpu_compare_ctrl: RTL and testbench

//  Shares one single-precision FPU compare unit between NUM_REQ requesters, e.g. the

---
 rtl/cpu_fpu_compare_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cpu_fpu_compare_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fpu_compare_ctrl.sv
// cpu_fpu_compare_ctrl
//   Arbitrates NUM_REQ requesters onto one shared single-precision compare unit.
//   Round-robin grant, FEQ/FLT/FLE/FMIN/FMAX decode, and local resolution of NaN,
//   both-zero equality and reserved-func cases without involving the unit.
// Ports
//   i_clock / i_reset            clock, asynchronous active-low reset
//   i_req_valid/func/op1/op2     per-requester request, held until accepted
//   o_req_accept                 one-hot accept pulse
//   o_rsp_valid                  one-hot response pulse; o_rsp_result/o_rsp_nv held
//   o_cmp_request/op1/op2        request and registered operands to the compare unit
//   i_cmp_ready/less/equal/min/max  compare unit results
module cpu_fpu_compare_ctrl #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*3-1:0]  i_req_func,
  input  logic [NUM_REQ*32-1:0] i_req_op1,
  input  logic [NUM_REQ*32-1:0] i_req_op2,
  output logic [NUM_REQ-1:0]    o_req_accept,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [31:0]           o_rsp_result,
  output logic                  o_rsp_nv,
  output logic                  o_cmp_request,
  output logic [31:0]           o_cmp_op1,
  output logic [31:0]           o_cmp_op2,
  input  logic                  i_cmp_ready,
  input  logic                  i_cmp_less,
  input  logic                  i_cmp_equal,
  input  logic [31:0]           i_cmp_min,
  input  logic [31:0]           i_cmp_max
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StBypass} state_e;

  typedef struct packed {
    logic        bypass;
    logic        nv;
    logic [31:0] result;
  } local_res_t;

  // Cases the compare unit cannot handle, resolved here instead.
  function automatic local_res_t classify(input logic [2:0] func, input logic [31:0] a,
                                          input logic [31:0] b);
    local_res_t r;
    logic nan_a, nan_b, snan_any, zero_both;
    nan_a     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    snan_any  = (nan_a && !a[22]) || (nan_b && !b[22]);
    zero_both = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    r = '0;
    if (func > 3'd4) begin
      r.bypass = 1'b1;
    end else if (nan_a || nan_b) begin
      r.bypass = 1'b1;
      case (func)
        3'd0:       r.nv = snan_any;
        3'd1, 3'd2: r.nv = 1'b1;
        default: begin
          r.nv = snan_any;
          if (nan_a && nan_b) r.result = 32'h7FC0_0000;
          else if (nan_a)     r.result = b;
          else                r.result = a;
        end
      endcase
    end else if (zero_both && (func <= 3'd2)) begin
      // +0 == -0: FEQ and FLE true, FLT false. FMIN/FMAX go to the unit.
      r.bypass = 1'b1;
      r.result = {31'd0, func != 3'd1};
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q;
  logic [2:0]          func_q;
  logic [31:0]         op1_q, op2_q, rsp_result_q;
  logic                rsp_nv_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id, cand;
  logic                accept;
  logic [2:0]          sel_func;
  logic [31:0]         sel_op1, sel_op2, unit_result;
  local_res_t          local_res;

  // Search starts one past the last grant and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!gnt_found && i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign sel_func  = i_req_func[gnt_id*3 +: 3];
  assign sel_op1   = i_req_op1[gnt_id*32 +: 32];
  assign sel_op2   = i_req_op2[gnt_id*32 +: 32];
  assign local_res = classify(sel_func, sel_op1, sel_op2);

  // Gated by reset so no accept pulse escapes while the block is held in reset.
  assign accept = i_reset && (state_q == StIdle) && !i_cmp_ready && gnt_found;

  always_comb begin
    case (func_q)
      3'd0:    unit_result = {31'd0, i_cmp_equal};
      3'd1:    unit_result = {31'd0, i_cmp_less};
      3'd2:    unit_result = {31'd0, i_cmp_less | i_cmp_equal};
      3'd3:    unit_result = i_cmp_min;
      default: unit_result = i_cmp_max;
    endcase
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = local_res.bypass ? StBypass : StIssue;
      StIssue:  if (i_cmp_ready) state_d = StDrain;
      StDrain:  if (!i_cmp_ready) state_d = StIdle;
      StBypass: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Request latch and response registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      func_q       <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      rsp_result_q <= '0;
      rsp_nv_q     <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        id_q     <= gnt_id;
        rr_ptr_q <= gnt_id;
        func_q   <= sel_func;
        op1_q    <= sel_op1;
        op2_q    <= sel_op2;
        if (local_res.bypass) begin
          rsp_result_q <= local_res.result;
          rsp_nv_q     <= local_res.nv;
          rsp_valid_q  <= NUM_REQ'(1) << gnt_id;
        end
      end
      if ((state_q == StIssue) && i_cmp_ready) begin
        rsp_result_q <= unit_result;
        rsp_nv_q     <= 1'b0;
        rsp_valid_q  <= NUM_REQ'(1) << id_q;
      end
    end
  end

  // Outputs
  always_comb begin
    o_req_accept  = accept ? (NUM_REQ'(1) << gnt_id) : '0;
    o_cmp_request = (state_q == StIssue);
    o_cmp_op1     = op1_q;
    o_cmp_op2     = op2_q;
    o_rsp_valid   = rsp_valid_q;
    o_rsp_result  = rsp_result_q;
    o_rsp_nv      = rsp_nv_q;
  end

endmodule

// File: tb/tb_cpu_fpu_compare_ctrl.sv
// Bench for cpu_fpu_compare_ctrl: behavioural compare-unit model, table vectors,
// round-robin, reset-while-busy and randomized transactions against a reference model.
module tb_cpu_fpu_compare_ctrl;
  localparam int unsigned NR  = 2;
  localparam int unsigned IDW = 1;
  localparam int          LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*3-1:0]   req_func = '0;
  logic [NR*32-1:0]  req_op1 = '0;
  logic [NR*32-1:0]  req_op2 = '0;
  logic [NR-1:0]     req_accept, rsp_valid;
  logic [31:0]       rsp_result, cmp_op1, cmp_op2;
  logic              rsp_nv, cmp_request;
  logic              cmp_ready = 1'b0;
  logic              cmp_less, cmp_equal;
  logic [31:0]       cmp_min, cmp_max;

  int unsigned cyc = 0;
  int          req_cycles = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        force_ready = 1'b0;
  int          ucnt = 0;
  logic [31:0] pool [12];

  cpu_fpu_compare_ctrl #(.NUM_REQ(NR), .ID_W(IDW)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_func   (req_func),
    .i_req_op1    (req_op1),
    .i_req_op2    (req_op2),
    .o_req_accept (req_accept),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .o_rsp_nv     (rsp_nv),
    .o_cmp_request(cmp_request),
    .o_cmp_op1    (cmp_op1),
    .o_cmp_op2    (cmp_op2),
    .i_cmp_ready  (cmp_ready),
    .i_cmp_less   (cmp_less),
    .i_cmp_equal  (cmp_equal),
    .i_cmp_min    (cmp_min),
    .i_cmp_max    (cmp_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cmp_request) req_cycles <= req_cycles + 1;

  // Sign-magnitude total order with -0 < +0.
  function automatic int fkey(input logic [31:0] x);
    int mag;
    mag = int'(x[30:0]);
    return x[31] ? (-mag - 1) : mag;
  endfunction

  // Compare unit: ready LAT cycles after request, held until request drops.
  always @(posedge clk) begin
    if (force_ready) begin
      cmp_ready <= 1'b1;
    end else if (!cmp_request) begin
      cmp_ready <= 1'b0;
      ucnt      <= 0;
    end else begin
      ucnt <= ucnt + 1;
      if (ucnt + 1 >= LAT) cmp_ready <= 1'b1;
    end
  end

  always_comb begin
    cmp_less  = fkey(cmp_op1) < fkey(cmp_op2);
    cmp_equal = (cmp_op1 == cmp_op2);
    cmp_min   = cmp_less ? cmp_op1 : cmp_op2;
    cmp_max   = cmp_less ? cmp_op2 : cmp_op1;
  end

  // Reference: {goes_local, nv, result}
  function automatic logic [33:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    bit na, nb, sig, lt, eq;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sig = (na && !a[22]) || (nb && !b[22]);
    if (f >= 3'd5) return {2'b10, 32'h0};
    if (na || nb) begin
      if (f == 3'd0) return {1'b1, sig, 32'h0};
      if (f <= 3'd2) return {2'b11, 32'h0};
      if (na && nb)  return {1'b1, sig, 32'h7FC0_0000};
      return {1'b1, sig, na ? b : a};
    end
    if (f <= 3'd2 && a[30:0] == 0 && b[30:0] == 0)
      return {2'b10, 31'h0, f != 3'd1};
    lt = fkey(a) < fkey(b);
    eq = (a == b);
    case (f)
      3'd0:    return {2'b00, 31'h0, eq};
      3'd1:    return {2'b00, 31'h0, lt};
      3'd2:    return {2'b00, 31'h0, lt | eq};
      3'd3:    return {2'b00, lt ? a : b};
      default: return {2'b00, lt ? b : a};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input int id, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_nv,
                        input logic exp_byp, input string name);
    bit got;
    int waited, t_acc, rc0;
    @(posedge clk); #1;
    req_valid[id]         = 1'b1;
    req_func[id*3 +: 3]   = f;
    req_op1[id*32 +: 32]  = a;
    req_op2[id*32 +: 32]  = b;
    got = 0; waited = 0;
    while (!got && waited < 60) begin
      @(negedge clk);
      if (req_accept[id]) got = 1; else waited++;
    end
    check({name, " accept"}, 32'(got), 32'd1);
    if (!got) begin req_valid[id] = 1'b0; return; end
    t_acc = int'(cyc);
    rc0   = req_cycles;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    got = 0; waited = 0;
    while (!got && waited < 30) begin
      @(negedge clk);
      if (rsp_valid != 0) got = 1; else waited++;
    end
    check({name, " rsp seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({name, " latency"}, 32'(int'(cyc) - t_acc), exp_byp ? 32'd1 : 32'd4);
    check({name, " rsp id"}, 32'(rsp_valid), 32'(NR'(1) << id));
    check({name, " result"}, rsp_result, exp_res);
    check({name, " nv"}, 32'(rsp_nv), 32'(exp_nv));
    if (exp_byp) check({name, " no unit req"}, 32'(req_cycles - rc0), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, res;
    logic        nv, byp;
    string       name;
  } vec_t;
  vec_t tbl [14];

  initial begin
    logic [33:0] r;
    int cnt, waited, id;
    bit got;
    logic [31:0] a, b;
    logic [2:0]  f;

    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
             32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
             32'hFFC0_0001, 32'h7FA0_0000};
    tbl[0]  = '{3'd1, 32'h3F800000, 32'h40000000, 32'h1,        1'b0, 1'b0, "flt 1<2"};
    tbl[1]  = '{3'd4, 32'hC0000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, "fmax"};
    tbl[2]  = '{3'd0, 32'h80000000, 32'h00000000, 32'h1,        1'b0, 1'b1, "feq -0 +0"};
    tbl[3]  = '{3'd2, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b1, 1'b1, "fle qnan"};
    tbl[4]  = '{3'd3, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1, "fmin snan"};
    tbl[5]  = '{3'd3, 32'h7FC00000, 32'h7FC00001, 32'h7FC00000, 1'b0, 1'b1, "fmin 2 qnan"};
    tbl[6]  = '{3'd6, 32'h3F800000, 32'h40000000, 32'h0,        1'b0, 1'b1, "reserved"};
    tbl[7]  = '{3'd0, 32'h3F800000, 32'h3F800000, 32'h1,        1'b0, 1'b0, "feq equal"};
    tbl[8]  = '{3'd1, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 1'b1, "flt zeros"};
    tbl[9]  = '{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, "fmin zeros"};
    tbl[10] = '{3'd2, 32'hBF800000, 32'hBF800000, 32'h1,        1'b0, 1'b0, "fle equal"};
    tbl[11] = '{3'd1, 32'hC0000000, 32'hBF800000, 32'h1,        1'b0, 1'b0, "flt negs"};
    tbl[12] = '{3'd0, 32'h7F800001, 32'h7F800001, 32'h0,        1'b1, 1'b1, "feq snan"};
    tbl[13] = '{3'd4, 32'h3F800000, 32'hFFC00000, 32'h3F800000, 1'b0, 1'b1, "fmax qnan"};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset accept", 32'(req_accept), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset result", rsp_result, 32'd0);
    check("reset cmp_request", 32'(cmp_request), 32'd0);
    rst_n = 1'b1;

    // Round robin with both requesters continuously valid
    req_func = {3'd4, 3'd4};
    req_op1  = {32'hC0000000, 32'hC0000000};
    req_op2  = {32'h3F800000, 32'h3F800000};
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      got = 0; waited = 0; id = 0;
      while (!got && waited < 60) begin
        @(negedge clk);
        if (req_accept != 0) got = 1; else waited++;
      end
      check("rr accept", 32'(got), 32'd1);
      id = req_accept[1] ? 1 : 0;
      check("rr order", 32'(id), 32'(k % 2));
      check("rr onehot", 32'(req_accept), 32'(NR'(1) << id));
      @(posedge clk); #1;
      if (k == 3) req_valid = '0;
      got = 0; waited = 0;
      while (!got && waited < 30) begin
        @(negedge clk);
        if (rsp_valid != 0) got = 1; else waited++;
      end
      check("rr rsp id", 32'(rsp_valid), 32'(NR'(1) << id));
      check("rr result", rsp_result, 32'h3F800000);
    end

    // Table vectors
    for (int i = 0; i < 14; i++)
      do_txn(i % NR, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].nv, tbl[i].byp,
             tbl[i].name);

    // Reset while in ISSUE with the unit stuck ready
    @(posedge clk); #1;
    req_func[2:0] = 3'd1; req_op1[31:0] = 32'h3F800000; req_op2[31:0] = 32'h40000000;
    req_valid[0] = 1'b1;
    got = 0; waited = 0;
    while (!got && waited < 60) begin
      @(negedge clk);
      if (req_accept[0]) got = 1; else waited++;
    end
    check("rst txn accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    force_ready  = 1'b1;
    @(posedge clk); #1;
    check("rst pre cmp_request", 32'(cmp_request), 32'd1);
    rst_n = 1'b0;
    req_valid = '1;
    req_func[5:3] = 3'd0; req_op1[63:32] = 32'h80000000; req_op2[63:32] = 32'h0;
    #1;
    check("rst cmp_request", 32'(cmp_request), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst accept", 32'(req_accept), 32'd0);
    check("rst result", rsp_result, 32'd0);
    check("rst nv", 32'(rsp_nv), 32'd0);
    check("rst cmp_op1", cmp_op1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_accept != 0 || rsp_valid != 0) cnt++;
    end
    check("blocked while ready", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;  // requester 0 gives up before ever being accepted
    force_ready  = 1'b0;
    do_txn(1, 3'd0, 32'h80000000, 32'h0, 32'h1, 1'b0, 1'b1, "post rst");
    do_txn(0, 3'd1, 32'h3F800000, 32'h40000000, 32'h1, 1'b0, 1'b0, "post rst unit");

    // Randomized against the reference model
    for (int n = 0; n < 200; n++) begin
      id = int'($urandom_range(0, NR - 1));
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 11)];
      b  = ($urandom_range(0, 4) == 0) ? a :
           (($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 11)]);
      r  = ref_model(f, a, b);
      do_txn(id, f, a, b, r[31:0], r[32], r[33], "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
